// File: rtl/barcode_entry_ctrl_if.sv
// Lookup handshake between the entry controller (master) and the item-lookup datapath (slave).
// The request is held high until a one-cycle ack; the code is stable while the request is high.
interface barcode_entry_ctrl_if;
    logic       lookup_req;
    logic [7:0] lookup_code;
    logic       lookup_ack;
    logic       lookup_found;

    modport master (
        output lookup_req,
        output lookup_code,
        input  lookup_ack,
        input  lookup_found
    );

    modport slave (
        input  lookup_req,
        input  lookup_code,
        output lookup_ack,
        output lookup_found
    );
endinterface

// File: rtl/barcode_entry_ctrl.sv
// Keypad barcode entry: debounces KEY[3:0], builds a 4-digit code, runs the req/ack item lookup.
// Latency: key press to FSM action 3+DEBOUNCE_CYCLES edges; lookup ack to result pulse 1 edge.
// Backpressure: none; key events arriving while a lookup is outstanding are dropped.
module barcode_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [3:0]           KEY,
    input  logic                 sw_barcode,
    barcode_entry_ctrl_if.master lookup,
    output logic [7:0]           entry_code,
    output logic [2:0]           entry_count,
    output logic                 sel_pulse,
    output logic                 add_pulse,
    output logic                 nf_pulse,
    output logic                 err_pulse,
    output logic                 busy
);
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {ENTRY, REQ} state_t;

    logic [3:0]     sync_a;
    logic [3:0]     sync_b;
    logic [3:0]     pressed;
    logic [3:0]     pressed_q;
    logic [3:0]     key_ev;
    logic [DBW-1:0] db_cnt [4];

    state_t         state;
    logic [TW-1:0]  tcnt;
    logic           digit_vld;
    logic [1:0]     digit;

    // db_cnt counts consecutive synchronized samples that disagree with the accepted state.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync_a    <= '1;
            sync_b    <= '1;
            pressed   <= '0;
            pressed_q <= '0;
            key_ev    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_a    <= KEY;
            sync_b    <= sync_a;
            pressed_q <= pressed;
            key_ev    <= pressed & ~pressed_q;
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] != pressed[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    pressed[i] <= ~sync_b[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // KEY3 outranks KEY2 outranks KEY1 when digit events coincide.
    always_comb begin
        digit_vld = |key_ev[3:1];
        digit     = 2'd3;
        if (key_ev[3])      digit = 2'd1;
        else if (key_ev[2]) digit = 2'd2;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state              <= ENTRY;
            tcnt               <= '0;
            entry_code         <= '0;
            entry_count        <= '0;
            lookup.lookup_req  <= 1'b0;
            lookup.lookup_code <= '0;
            sel_pulse          <= 1'b0;
            add_pulse          <= 1'b0;
            nf_pulse           <= 1'b0;
            err_pulse          <= 1'b0;
            busy               <= 1'b0;
        end else begin
            sel_pulse <= 1'b0;
            add_pulse <= 1'b0;
            nf_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                ENTRY: begin
                    if (key_ev[0]) begin
                        if (!sw_barcode) begin
                            sel_pulse <= 1'b1;
                        end else if (entry_count == 3'd4) begin
                            lookup.lookup_code <= entry_code;
                            lookup.lookup_req  <= 1'b1;
                            busy               <= 1'b1;
                            tcnt               <= '0;
                            state              <= REQ;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end else if (digit_vld && entry_count != 3'd4) begin
                        entry_code  <= {entry_code[5:0], digit};
                        entry_count <= entry_count + 3'd1;
                    end
                end
                REQ: begin
                    // An ack in the final timeout cycle still counts as a lookup result.
                    if (lookup.lookup_ack || tcnt == TO_LAST) begin
                        lookup.lookup_req <= 1'b0;
                        busy              <= 1'b0;
                        entry_code        <= '0;
                        entry_count       <= '0;
                        state             <= ENTRY;
                        if (lookup.lookup_ack) begin
                            add_pulse <= lookup.lookup_found;
                            nf_pulse  <= ~lookup.lookup_found;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end
endmodule

// File: doc/barcode_entry_ctrl.md
# barcode_entry_ctrl

Sequences keypad barcode entry for the sale terminal. Debounces the four active-low push buttons and assembles a 4-digit barcode from the digit keys. On a commit, issues a req/ack lookup to the item-lookup datapath and reports the result as single-cycle status pulses. It sits between the board inputs (KEY, SW) and the item ROM/cart logic; display and VGA blocks read its entry outputs.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a press or release (≥1).
- TIMEOUT_CYCLES, 1024: cycles to wait for lookup_ack before aborting (≥2).
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- KEY  in  4  raw buttons, active-low, asynchronous. KEY[3]=digit 1, KEY[2]=digit 2, KEY[1]=digit 3, KEY[0]=select.
- sw_barcode  in  1  SW[0]; 1 = select commits the barcode, 0 = select is an interactive select.
- lookup_ack  in  1  one-cycle acknowledge from the lookup datapath.
- lookup_found  in  1  lookup result, valid only in a lookup_ack cycle.
- entry_code  out  8  digit buffer; first-entered digit in [7:6]. Each digit is 2 bits: 1=01, 2=10, 3=11; 00 means an empty slot.
- entry_count  out  3  digits entered, 0–4.
- lookup_req  out  1  lookup request; held high until acknowledged.
- lookup_code  out  8  code under lookup; stable while lookup_req=1.
- sel_pulse  out  1  one-cycle interactive-select event.
- add_pulse  out  1  one-cycle pulse: lookup found.
- nf_pulse  out  1  one-cycle pulse: lookup not found.
- err_pulse  out  1  one-cycle pulse: short commit or timeout.
- busy  out  1  high while in the REQ state.

## Operation
- Input conditioning, per key:
  - 2-flop synchronizer, then debouncer.
  - An accepted press yields exactly one event.
  - The next event on that key requires an accepted release first.
  - Each key is independent.
- Simultaneous events in one cycle: only the highest-priority event is processed; the rest are dropped. Priority KEY0 > KEY3 > KEY2 > KEY1.
- FSM states: ENTRY (reset state) and REQ.
- ENTRY, digit event with entry_count<4:
  - entry_code shifts left by 2 and the digit enters [1:0].
  - entry_count increments.
  - After 4 digits the first digit sits in [7:6].
- ENTRY, digit event with entry_count=4: ignored (no wrap, no error).
- ENTRY, select event:
  - sw_barcode=0: sel_pulse fires; buffer unchanged.
  - sw_barcode=1, entry_count=4: latch lookup_code←entry_code, assert lookup_req, go to REQ.
  - sw_barcode=1, entry_count<4: err_pulse fires; buffer kept.
- Digits are accepted regardless of sw_barcode.
- REQ:
  - All key events are dropped. Debouncers keep running, so a key still held on exit produces no new event.
  - A cycle counter starts at 0.
  - On lookup_ack: drop lookup_req, clear entry_code/entry_count, pulse add_pulse (found=1) or nf_pulse (found=0), return to ENTRY.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: drop lookup_req, clear the buffer, pulse err_pulse, return to ENTRY.
  - If ack arrives in that same final cycle, ack wins.
- lookup_ack outside REQ is ignored.
- Reset: all outputs 0, state ENTRY, debouncers in the released state with counters 0, synchronizers set to 1. Reset mid-REQ drops lookup_req on the next edge without emitting a pulse.

## Timing
- Press latency: KEY low and held from before edge 0 produces a registered event at edge 2+DEBOUNCE_CYCLES (4 synchronizer/debounce stages counted). The FSM acts on it at the following edge, so buffer, output or pulse changes appear at edge 3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- lookup_req rises in the same cycle the FSM enters REQ.
- lookup_ack sampled at edge n: lookup_req low, result pulse high and buffer cleared after edge n. The pulse lasts one cycle.
- Timeout: lookup_req high for exactly TIMEOUT_CYCLES cycles.
- All *_pulse outputs are registered and exactly one cycle wide; at most one pulse per cycle.

## Test plan
- Reset: hold RESET_N=0 for 3 cycles with keys toggling -> all outputs 0, entry_count=0; no event after release until a fresh press.
- Entry 1213: press KEY3, KEY2, KEY3, KEY1 (10 cycles each, 20 cycles apart), then set sw_barcode=1 and press KEY0 -> entry_code=0x67, entry_count=4, lookup_req=1, lookup_code=0x67, busy=1.
- Ack: respond with lookup_ack=1, found=1 after 5 cycles -> next cycle add_pulse=1 for 1 cycle, lookup_req=0, entry_code=0, entry_count=0. Repeat with found=0 -> nf_pulse.
- Short commit and interactive select: enter "3", sw_barcode=1, KEY0 -> err_pulse, entry_code=0x03 kept. Then sw_barcode=0, KEY0 -> sel_pulse once, no lookup_req.
- Timeout and overflow: commit, never ack -> lookup_req high exactly TIMEOUT_CYCLES cycles, then err_pulse. Enter 5 digits -> fifth ignored, entry_count=4.
- Debounce and priority: a 2-cycle KEY3 glitch -> no change. KEY0 and KEY3 events in the same cycle with sw_barcode=0 -> sel_pulse only, entry_count unchanged.
